uart_receiver: RTL and testbench

- Serial-to-parallel UART RX stage that consumes the line driven by the transmitter.
- Receives 8N1 frames: 1 start bit, 8 data bits LSB-first, 1 stop bit. Even parity is optional.
- Samples the line at mid-bit using a baud counter.
- Presents each received byte as a one-cycle valid pulse to the downstream consumer.

---
 rtl/uart_pkg.sv | 20 ++
 rtl/uart_sync.sv | 21 ++
 rtl/uart_receiver.sv | 135 +++++++++++++
 tb/tb_uart_receiver.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: rx state encoding, counter width and default bit period.
// Optional even parity is enabled by defining UART_RX_PARITY_EN.
package uart_pkg;

   localparam int CNT_W = 13;

   // 50 MHz / 28800 baud, shared with the transmitter
   localparam logic [CNT_W-1:0] CLKS_PER_BIT_DEF = 13'd1736;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      PARITY,
      STOP,
      DONE,
      BREAK
   } rx_state_t;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for an asynchronous input; resets to 1 (idle line level).
module uart_sync (
   input  logic clk,
   input  logic rst_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta <= 1'b1;
         q    <= 1'b1;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/uart_receiver.sv
// UART RX: 8N1 frames sampled at mid-bit, byte delivered as a one-cycle valid pulse.
// Even parity between D7 and stop is added when UART_RX_PARITY_EN is defined.
//
//   state  | meaning
//   IDLE   | line idle, waiting for falling edge
//   START  | half-bit wait, confirm start bit at its centre
//   DATA   | sample 8 data bits, LSB first
//   PARITY | sample even-parity bit (UART_RX_PARITY_EN only)
//   STOP   | sample stop bit
//   DONE   | one cycle: deliver byte or flag parity error
//   BREAK  | stop bit was low; wait for line to return high
module uart_receiver
   import uart_pkg::*;
#(
   parameter logic [CNT_W-1:0] CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx_i,
   output logic [7:0] data_o,
   output logic       valid_o,
   output logic       busy_o,
   output logic       frame_err_o,
   output logic       parity_err_o
);

   localparam logic [CNT_W-1:0] HALF_BIT = CLKS_PER_BIT >> 1;

   rx_state_t        state, state_nxt;
   logic             rx_s;
   logic [CNT_W-1:0] baud_cnt;
   logic [CNT_W-1:0] baud_lim;
   logic             at_lim;
   logic             counting;
   logic [2:0]       bit_cnt;
   logic [7:0]       shift_reg;
   logic             perr;

   uart_sync u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (rx_i),
      .q     (rx_s)
   );

   assign baud_lim = (state == START) ? HALF_BIT - CNT_W'(1) : CLKS_PER_BIT - CNT_W'(1);
   assign at_lim   = (baud_cnt == baud_lim);
   assign counting = (state == START) || (state == DATA) || (state == PARITY) || (state == STOP);
   assign busy_o   = (state != IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:   if (!rx_s) state_nxt = START;
         START:  if (at_lim) state_nxt = rx_s ? IDLE : DATA;
         DATA: begin
            if (at_lim && bit_cnt == 3'd7) begin
`ifdef UART_RX_PARITY_EN
               state_nxt = PARITY;
`else
               state_nxt = STOP;
`endif
            end
         end
         PARITY: if (at_lim) state_nxt = STOP;
         STOP:   if (at_lim) state_nxt = rx_s ? DONE : BREAK;
         DONE:   state_nxt = IDLE;
         BREAK:  if (rx_s) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         baud_cnt    <= '0;
         bit_cnt     <= '0;
         shift_reg   <= '0;
         data_o      <= '0;
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;
      end else begin
         valid_o     <= 1'b0;
         frame_err_o <= 1'b0;

         // counter restarts on every state change so each phase measures from its own entry
         if (!counting || at_lim || state_nxt != state) baud_cnt <= '0;
         else                                           baud_cnt <= baud_cnt + CNT_W'(1);

         case (state)
            START: bit_cnt <= '0;
            DATA: begin
               if (at_lim) begin
                  shift_reg[bit_cnt] <= rx_s;
                  bit_cnt            <= bit_cnt + 3'd1;
               end
            end
            STOP: if (at_lim && !rx_s) frame_err_o <= 1'b1;
            DONE: begin
               if (!perr) begin
                  data_o  <= shift_reg;
                  valid_o <= 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

`ifdef UART_RX_PARITY_EN
   logic parity_bit;
   logic parity_err_q;

   assign perr         = ^shift_reg ^ parity_bit;
   assign parity_err_o = parity_err_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         parity_bit   <= 1'b0;
         parity_err_q <= 1'b0;
      end else begin
         parity_err_q <= (state == DONE) && perr;
         if (state == PARITY && at_lim) parity_bit <= rx_s;
      end
   end
`else
   assign perr         = 1'b0;
   assign parity_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_uart_receiver.sv
// Directed self-checking bench for uart_receiver with CLKS_PER_BIT=16.
module tb_uart_receiver;

   localparam int CPB = 16;
   localparam int HALF = CPB / 2;
`ifdef UART_RX_PARITY_EN
   localparam int LAT = 3 + HALF + 10 * CPB;
`else
   localparam int LAT = 3 + HALF + 9 * CPB;
`endif

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx_i = 1'b1;
   logic [7:0] data_o;
   logic       valid_o, busy_o, frame_err_o, parity_err_o;

   int checks = 0;
   int fails = 0;
   int cyc = 0;
   int t_start = 0;

   logic [7:0] vq[$];
   int         vc[$];
   int         ferr_n = 0, perr_n = 0, excl_n = 0, busy_n = 0;

   uart_receiver #(.CLKS_PER_BIT(13'd16)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .rx_i         (rx_i),
      .data_o       (data_o),
      .valid_o      (valid_o),
      .busy_o       (busy_o),
      .frame_err_o  (frame_err_o),
      .parity_err_o (parity_err_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rst_n) begin
         if (valid_o) begin
            vq.push_back(data_o);
            vc.push_back(cyc);
         end
         if (frame_err_o) ferr_n++;
         if (parity_err_o) perr_n++;
         if (int'(valid_o) + int'(frame_err_o) + int'(parity_err_o) > 1) excl_n++;
         if (busy_o) busy_n++;
      end
   end

   task automatic drive_bit(input logic b);
      @(posedge clk);
      #1 rx_i = b;
      repeat (CPB - 1) @(posedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par, input logic stop);
      @(posedge clk);
      #1 rx_i = 1'b0;
      t_start = cyc;
      repeat (CPB - 1) @(posedge clk);
      for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef UART_RX_PARITY_EN
      drive_bit(par);
`else
      if (par === 1'bz) rx_i = 1'b1;
`endif
      drive_bit(stop);
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      rx_i  = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (data_o !== 8'h00) begin fails++; $display("FAIL reset_data: got %h want 00", data_o); end
      checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", valid_o); end
      checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b want 0", busy_o); end
      checks++; if (frame_err_o !== 1'b0) begin fails++; $display("FAIL reset_ferr: got %b want 0", frame_err_o); end
      checks++; if (parity_err_o !== 1'b0) begin fails++; $display("FAIL reset_perr: got %b want 0", parity_err_o); end
      rst_n = 1'b1;
      repeat (5) @(posedge clk);
   endtask

   task automatic test_loopback();
      int v0, f0, lat;
      v0 = vq.size(); f0 = ferr_n + perr_n;
      send_frame(8'hA5, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (vq.size() - v0 !== 1) begin fails++; $display("FAIL loop_count: got %0d want 1", vq.size() - v0); end
      checks++; if (vq[v0] !== 8'hA5) begin fails++; $display("FAIL loop_pulse_data: got %h want a5", vq[v0]); end
      checks++; if (data_o !== 8'hA5) begin fails++; $display("FAIL loop_data: got %h want a5", data_o); end
      checks++; if (ferr_n + perr_n - f0 !== 0) begin fails++; $display("FAIL loop_errs: got %0d want 0", ferr_n + perr_n - f0); end
      checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL loop_busy: got %b want 0", busy_o); end
      lat = vc[v0] - (t_start + 1);
      checks++; if (lat < LAT - 1 || lat > LAT + 1) begin fails++; $display("FAIL loop_latency: got %0d want %0d", lat, LAT); end
   endtask

   task automatic test_back_to_back();
      int v0;
      v0 = vq.size();
      send_frame(8'h00, 1'b0, 1'b1);
      send_frame(8'hFF, 1'b0, 1'b1);
      send_frame(8'h3C, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (vq.size() - v0 !== 3) begin fails++; $display("FAIL b2b_count: got %0d want 3", vq.size() - v0); end
      checks++; if (vq[v0] !== 8'h00) begin fails++; $display("FAIL b2b_byte0: got %h want 00", vq[v0]); end
      checks++; if (vq[v0+1] !== 8'hFF) begin fails++; $display("FAIL b2b_byte1: got %h want ff", vq[v0+1]); end
      checks++; if (vq[v0+2] !== 8'h3C) begin fails++; $display("FAIL b2b_byte2: got %h want 3c", vq[v0+2]); end
   endtask

   task automatic test_glitch();
      int v0, f0, b0;
      v0 = vq.size(); f0 = ferr_n; b0 = busy_n;
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (5) @(posedge clk);
      #1 rx_i = 1'b1;
      repeat (30) @(posedge clk);
      #1;
      checks++; if (busy_n - b0 < 1 || busy_n - b0 > HALF + 2) begin fails++; $display("FAIL glitch_busy_cycles: got %0d want 1..%0d", busy_n - b0, HALF + 2); end
      checks++; if (vq.size() - v0 !== 0) begin fails++; $display("FAIL glitch_valid: got %0d want 0", vq.size() - v0); end
      checks++; if (ferr_n - f0 !== 0) begin fails++; $display("FAIL glitch_ferr: got %0d want 0", ferr_n - f0); end
      checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL glitch_idle: got %b want 0", busy_o); end
   endtask

   task automatic test_framing();
      int v0, f0;
      v0 = vq.size(); f0 = ferr_n;
      send_frame(8'h55, 1'b0, 1'b0);
      repeat (40) @(posedge clk);
      #1;
      checks++; if (ferr_n - f0 !== 1) begin fails++; $display("FAIL frame_err_count: got %0d want 1", ferr_n - f0); end
      checks++; if (vq.size() - v0 !== 0) begin fails++; $display("FAIL frame_valid: got %0d want 0", vq.size() - v0); end
      checks++; if (data_o !== 8'h3C) begin fails++; $display("FAIL frame_data_hold: got %h want 3c", data_o); end
      checks++; if (busy_o !== 1'b1) begin fails++; $display("FAIL frame_break_busy: got %b want 1", busy_o); end
      rx_i = 1'b1;
      repeat (10) @(posedge clk);
      #1;
      checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL frame_release: got %b want 0", busy_o); end
      send_frame(8'h12, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (vq.size() - v0 !== 1) begin fails++; $display("FAIL frame_next_count: got %0d want 1", vq.size() - v0); end
      checks++; if (data_o !== 8'h12) begin fails++; $display("FAIL frame_next_data: got %h want 12", data_o); end
      checks++; if (ferr_n - f0 !== 1) begin fails++; $display("FAIL frame_next_ferr: got %0d want 1", ferr_n - f0); end
   endtask

   task automatic test_reset_midframe();
      logic [7:0] d;
      int v0;
      d = 8'hC3;
      @(posedge clk);
      #1 rx_i = 1'b0;
      repeat (CPB - 1) @(posedge clk);
      for (int i = 0; i < 4; i++) drive_bit(d[i]);
      @(posedge clk);
      #1 rx_i = d[4];
      repeat (HALF) @(posedge clk);
      #1 rst_n = 1'b0;
      #1;
      checks++; if (data_o !== 8'h00) begin fails++; $display("FAIL rst_mid_data: got %h want 00", data_o); end
      checks++; if (busy_o !== 1'b0) begin fails++; $display("FAIL rst_mid_busy: got %b want 0", busy_o); end
      checks++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rst_mid_valid: got %b want 0", valid_o); end
      rx_i = 1'b1;
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      v0 = vq.size();
      send_frame(8'hC3, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (vq.size() - v0 !== 1) begin fails++; $display("FAIL rst_next_count: got %0d want 1", vq.size() - v0); end
      checks++; if (data_o !== 8'hC3) begin fails++; $display("FAIL rst_next_data: got %h want c3", data_o); end
   endtask

`ifdef UART_RX_PARITY_EN
   task automatic test_parity();
      int v0, p0;
      v0 = vq.size(); p0 = perr_n;
      send_frame(8'h07, 1'b1, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (vq.size() - v0 !== 1) begin fails++; $display("FAIL par_ok_count: got %0d want 1", vq.size() - v0); end
      checks++; if (data_o !== 8'h07) begin fails++; $display("FAIL par_ok_data: got %h want 07", data_o); end
      checks++; if (perr_n - p0 !== 0) begin fails++; $display("FAIL par_ok_perr: got %0d want 0", perr_n - p0); end
      send_frame(8'h07, 1'b0, 1'b1);
      repeat (10) @(posedge clk);
      #1;
      checks++; if (perr_n - p0 !== 1) begin fails++; $display("FAIL par_bad_perr: got %0d want 1", perr_n - p0); end
      checks++; if (vq.size() - v0 !== 1) begin fails++; $display("FAIL par_bad_valid: got %0d want 1", vq.size() - v0); end
   endtask
`endif

   task automatic test_exclusive();
      checks++; if (excl_n !== 0) begin fails++; $display("FAIL pulse_exclusive: got %0d overlap cycles want 0", excl_n); end
   endtask

   initial begin
      test_reset();
      test_loopback();
      test_back_to_back();
      test_glitch();
      test_framing();
      test_reset_midframe();
`ifdef UART_RX_PARITY_EN
      test_parity();
`endif
      test_exclusive();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end

endmodule
